// File: rtl/x_byte_ser_if.sv
// Word-pair intake and command-byte output signals of the x_byte serializer.
// The slave modport is the serializer's view; the master modport is the host/link side.
interface x_byte_ser_if;
   logic        i_valid;
   logic        o_accept;
   logic [63:0] i_data_a;
   logic [63:0] i_data_b;
   logic        o_valid;
   logic        i_accept;
   logic [7:0]  o_cmd;
   logic        o_busy;

   modport slave (
      input  i_valid,
      input  i_data_a,
      input  i_data_b,
      input  i_accept,
      output o_accept,
      output o_valid,
      output o_cmd,
      output o_busy
   );

   modport master (
      output i_valid,
      output i_data_a,
      output i_data_b,
      output i_accept,
      input  o_accept,
      input  o_valid,
      input  o_cmd,
      input  o_busy
   );
endinterface

// File: rtl/x_byte_ser.sv
// x_byte command serializer: word pair -> 16 SHIFT_A, 16 SHIFT_B nibbles, then APPLY_AB.
// Optional X_BYTE_SER_SKIP_B_EN omits SHIFT_B when bank B repeats the last fully sent word.
module x_byte_ser #(
   parameter int unsigned GAP_CYCLES = 1
) (
   input logic         i_clk,
   input logic         i_rst,
   x_byte_ser_if.slave bus
);

   localparam logic [3:0] OpShiftA = 4'h0;
   localparam logic [3:0] OpShiftB = 4'h1;
   localparam logic [7:0] CmdApply = 8'h20;
   localparam logic [3:0] GapLoad  = 4'(GAP_CYCLES - 1);

   typedef enum logic [2:0] {
      StIdle,
      StShiftA,
      StShiftB,
      StApply,
      StGap
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  idx_q, idx_d;
   logic [3:0]  gap_q, gap_d;
   logic [63:0] a_q, a_d;
   logic [63:0] b_q, b_d;
   logic        valid_q, valid_d;
   logic [7:0]  cmd_q, cmd_d;
   logic        busy_q, busy_d;
   logic        accept_q, accept_d;

`ifdef X_BYTE_SER_SKIP_B_EN
   logic [63:0] last_b_q, last_b_d;
   logic        skip_q, skip_d;
`endif

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      gap_d   = gap_q;
      a_d     = a_q;
      b_d     = b_q;
`ifdef X_BYTE_SER_SKIP_B_EN
      last_b_d = last_b_q;
      skip_d   = skip_q;
`endif

      unique case (state_q)
         StIdle: begin
            if (bus.i_valid) begin
               a_d     = bus.i_data_a;
               b_d     = bus.i_data_b;
               idx_d   = 4'hF;
               state_d = StShiftA;
`ifdef X_BYTE_SER_SKIP_B_EN
               skip_d  = (bus.i_data_b == last_b_q);
`endif
            end
         end
         StShiftA: begin
            if (bus.i_accept) begin
               if (idx_q == 4'd0) begin
                  idx_d   = 4'hF;
`ifdef X_BYTE_SER_SKIP_B_EN
                  state_d = skip_q ? StApply : StShiftB;
`else
                  state_d = StShiftB;
`endif
               end else begin
                  idx_d = idx_q - 4'd1;
               end
            end
         end
         StShiftB: begin
            if (bus.i_accept) begin
               if (idx_q == 4'd0) begin
                  idx_d   = 4'hF;
                  state_d = StApply;
`ifdef X_BYTE_SER_SKIP_B_EN
                  last_b_d = b_q;
`endif
               end else begin
                  idx_d = idx_q - 4'd1;
               end
            end
         end
         // APPLY is fire-and-forget: the receiver drops its accept in response to it.
         StApply: begin
            state_d = StGap;
            gap_d   = GapLoad;
         end
         StGap: begin
            if (gap_q == 4'd0) begin
               state_d = StIdle;
            end else begin
               gap_d = gap_q - 4'd1;
            end
         end
         default: state_d = StIdle;
      endcase

      // Outputs are registered copies decoded from the next state.
      valid_d  = 1'b0;
      cmd_d    = 8'h00;
      busy_d   = (state_d != StIdle);
      accept_d = (state_d == StIdle);
      unique case (state_d)
         StShiftA: begin
            valid_d = 1'b1;
            cmd_d   = {OpShiftA, a_d[{idx_d, 2'b00} +: 4]};
         end
         StShiftB: begin
            valid_d = 1'b1;
            cmd_d   = {OpShiftB, b_d[{idx_d, 2'b00} +: 4]};
         end
         StApply: begin
            valid_d = 1'b1;
            cmd_d   = CmdApply;
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q  <= StIdle;
         idx_q    <= 4'hF;
         gap_q    <= 4'd0;
         a_q      <= 64'd0;
         b_q      <= 64'd0;
         valid_q  <= 1'b0;
         cmd_q    <= 8'h00;
         busy_q   <= 1'b0;
         accept_q <= 1'b1;
`ifdef X_BYTE_SER_SKIP_B_EN
         last_b_q <= 64'd0;
         skip_q   <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         gap_q    <= gap_d;
         a_q      <= a_d;
         b_q      <= b_d;
         valid_q  <= valid_d;
         cmd_q    <= cmd_d;
         busy_q   <= busy_d;
         accept_q <= accept_d;
`ifdef X_BYTE_SER_SKIP_B_EN
         last_b_q <= last_b_d;
         skip_q   <= skip_d;
`endif
      end
   end

   assign bus.o_valid  = valid_q;
   assign bus.o_cmd    = cmd_q;
   assign bus.o_busy   = busy_q;
   assign bus.o_accept = accept_q;

endmodule

// File: tb/tb_x_byte_ser.sv
// Scoreboard bench for x_byte_ser: stimulus pushes expected bytes, a negedge monitor
// pops them on each consumed byte and checks the gap and a model receiver's banks on APPLY.
module tb_x_byte_ser;

   localparam int unsigned GAP = 3;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   x_byte_ser_if bus();

   x_byte_ser #(.GAP_CYCLES(GAP)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   int vectors = 0;
   int miscompares = 0;

   logic [7:0]   exp_q[$];
   logic [127:0] pair_q[$];
   logic [63:0]  rx_a = 64'd0;
   logic [63:0]  rx_b = 64'd0;
   int           gap_left = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_stream(input logic [63:0] a, input logic [63:0] b, input bit skip);
      for (int i = 15; i >= 0; i--) exp_q.push_back({4'h0, a[i*4 +: 4]});
      if (!skip) for (int i = 15; i >= 0; i--) exp_q.push_back({4'h1, b[i*4 +: 4]});
      exp_q.push_back(8'h20);
      pair_q.push_back({a, b});
   endtask

   // Monitor: a byte is consumed when accepted, or unconditionally if it is APPLY.
   always @(negedge clk) begin
      logic [7:0]   e;
      logic [127:0] p;
      if (rst) begin
         rx_a     = 64'd0;
         rx_b     = 64'd0;
         gap_left = 0;
      end else begin
         if (gap_left > 0) begin
            chk("gap_valid", bus.o_valid, 1'b0);
            chk("gap_accept", bus.o_accept, 1'b0);
            gap_left--;
         end
         if (!bus.o_valid) begin
            chk("idle_cmd", bus.o_cmd, 8'h00);
         end else if (exp_q.size() == 0) begin
            chk("spurious_valid", bus.o_valid, 1'b0);
         end else begin
            e = exp_q[0];
            chk("cmd", bus.o_cmd, e);
            if (bus.i_accept || e == 8'h20) begin
               void'(exp_q.pop_front());
               case (bus.o_cmd[7:4])
                  4'h0: rx_a = {rx_a[59:0], bus.o_cmd[3:0]};
                  4'h1: rx_b = {rx_b[59:0], bus.o_cmd[3:0]};
                  default: begin
                     gap_left = GAP;
                     if (pair_q.size() == 0) begin
                        chk("unexpected_apply", 1'b1, 1'b0);
                     end else begin
                        p = pair_q.pop_front();
                        chk("rx_bank_a", rx_a, p[127:64]);
                        chk("rx_bank_b", rx_b, p[63:0]);
                     end
                  end
               endcase
            end
         end
      end
   end

   // exp_len counts clock edges from capture until o_accept is seen high again.
   task automatic send(input logic [63:0] a, input logic [63:0] b, input bit skip,
                       input int exp_len, input int drop_at, input int drop_len,
                       input bit hold, input logic [63:0] na, input logic [63:0] nb,
                       input int rst_at);
      int n;
      bit done;
      n = 0;
      while (!bus.o_accept && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("accept_before_send", bus.o_accept, 1'b1);
      push_stream(a, b, skip);
      bus.i_valid  = 1'b1;
      bus.i_data_a = a;
      bus.i_data_b = b;
      @(posedge clk);
      #1;
      chk("busy_after_capture", bus.o_busy, 1'b1);
      chk("accept_after_capture", bus.o_accept, 1'b0);
      chk("first_byte", bus.o_cmd, {4'h0, a[63:60]});
      if (hold) begin
         bus.i_data_a = na;
         bus.i_data_b = nb;
      end else begin
         bus.i_valid = 1'b0;
      end
      n    = 0;
      done = 1'b0;
      while (!done && n < 200) begin
         @(posedge clk);
         #1;
         n++;
         if (n == rst_at) begin
            rst          = 1'b1;
            bus.i_valid  = 1'b1;
            bus.i_data_a = 64'hDEAD_BEEF_0000_1111;
            bus.i_data_b = 64'h2222_3333_CAFE_F00D;
            @(posedge clk);
            #1;
            chk("rst_valid", bus.o_valid, 1'b0);
            chk("rst_busy", bus.o_busy, 1'b0);
            chk("rst_accept", bus.o_accept, 1'b1);
            chk("rst_cmd", bus.o_cmd, 8'h00);
            rst         = 1'b0;
            bus.i_valid = 1'b0;
            exp_q.delete();
            pair_q.delete();
            @(posedge clk);
            #1;
            chk("rst_no_capture", bus.o_busy, 1'b0);
            return;
         end
         if (n == drop_at) bus.i_accept = 1'b0;
         if (n == drop_at + drop_len) bus.i_accept = 1'b1;
         if (bus.o_accept) done = 1'b1;
      end
      chk("cycles_to_idle", n, exp_len);
      chk("stream_drained", exp_q.size(), 0);
      chk("pairs_drained", pair_q.size(), 0);
      chk("idle_busy", bus.o_busy, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      rst          = 1'b1;
      bus.i_valid  = 1'b0;
      bus.i_accept = 1'b1;
      bus.i_data_a = 64'd0;
      bus.i_data_b = 64'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_valid", bus.o_valid, 1'b0);
      chk("reset_cmd", bus.o_cmd, 8'h00);
      chk("reset_busy", bus.o_busy, 1'b0);
      chk("reset_accept", bus.o_accept, 1'b1);
      rst = 1'b0;

      // Basic pair, full throughput: 32 + 1 + GAP edges.
      send(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b0, 36, -1, 0,
           1'b0, 64'd0, 64'd0, -1);
      // Backpressure at nibble 5 of A for 3 cycles.
      send(64'h0123_4567_89AB_CDEF, 64'h1111_2222_3333_4444, 1'b0, 39, 5, 3,
           1'b0, 64'd0, 64'd0, -1);
      // i_accept low during the APPLY cycle.
      send(64'hA5A5_5A5A_0F0F_F0F0, 64'h1357_9BDF_2468_ACE0, 1'b0, 36, 32, 1,
           1'b0, 64'd0, 64'd0, -1);
      // Back-to-back with i_valid held and new data applied while busy.
      send(64'h8899_AABB_CCDD_EEFF, 64'h0011_2233_4455_6677, 1'b0, 36, -1, 0,
           1'b1, 64'hCAFE_BABE_1234_5678, 64'h9ABC_DEF0_0FED_CBA9, -1);
      send(64'hCAFE_BABE_1234_5678, 64'h9ABC_DEF0_0FED_CBA9, 1'b0, 36, -1, 0,
           1'b0, 64'd0, 64'd0, -1);
      // Reset at nibble 20, in SHIFT_B.
      send(64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 1'b0, 0, -1, 0,
           1'b0, 64'd0, 64'd0, 20);
      send(64'h3141_5926_5358_9793, 64'h2718_2818_2845_9045, 1'b0, 36, -1, 0,
           1'b0, 64'd0, 64'd0, -1);
      // Same bank B again: skipped only when the option is built in.
`ifdef X_BYTE_SER_SKIP_B_EN
      send(64'h6626_0693_0040_1550, 64'h2718_2818_2845_9045, 1'b1, 20, -1, 0,
           1'b0, 64'd0, 64'd0, -1);
`else
      send(64'h6626_0693_0040_1550, 64'h2718_2818_2845_9045, 1'b0, 36, -1, 0,
           1'b0, 64'd0, 64'd0, -1);
`endif
      repeat (5) @(posedge clk);
      #1;
      chk("final_idle_valid", bus.o_valid, 1'b0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
